// File: rtl/xbar_pkg.sv
// Shared helpers for the crossbar slice.
// Width functions let each module size its index and counter fields from its own
// parameters. Parameter-dependent types are therefore declared locally in each module.
package xbar_pkg;

  // Width of a master index. A single-master crossbar still gets a 1-bit field.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy counter that must also represent the value 'depth'.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rd_order_fifo.sv
// Order FIFO: DEPTH entries of W-bit master indices, in issue order.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push, din  write din at the tail (caller never pushes when full)
//   pop        drop the head entry (caller never pops when empty)
//   head       entry at the head (valid only while count != 0)
//   count      current occupancy, 0..DEPTH
module rd_order_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb head = mem[rd_ptr];

endmodule

// File: rtl/rd_resp_collector.sv
// Slave-port read-response collector.
// Records the target master of every issued read in an order FIFO and forwards
// only the response from the master at the FIFO head, so responses reach the
// slave port in request order, registered with 1-cycle latency.
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   req_valid, req_mst  read issued to master req_mst this cycle
//   req_ready           order FIFO has room (low during reset)
//   m_rdata/m_resp/m_ack per-master response bundles, master i at slice i
//   s_rdata/s_resp/s_ack registered response bundle to the slave port
//   outstanding         FIFO occupancy
//   err_unexpected      sticky flag: stray ack or out-of-range req_mst
//   err_clr             synchronous clear of err_unexpected
module rd_resp_collector
  import xbar_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NMST   = 4,
  parameter int DEPTH  = 8,
  localparam int MIDX_W = idx_width(NMST),
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   req_valid,
  input  logic [MIDX_W-1:0]      req_mst,
  output logic                   req_ready,
  input  logic [NMST*DWIDTH-1:0] m_rdata,
  input  logic [NMST-1:0]        m_resp,
  input  logic [NMST-1:0]        m_ack,
  output logic [DWIDTH-1:0]      s_rdata,
  output logic                   s_resp,
  output logic                   s_ack,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   err_unexpected,
  input  logic                   err_clr
);

  typedef logic [MIDX_W-1:0] mst_idx_t;

  mst_idx_t          head;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              idx_ok;
  logic              push;
  logic              match;
  logic              err_set;
  logic [NMST-1:0]   head_oh;
  logic [DWIDTH-1:0] sel_rdata;
  logic              sel_resp;

  rd_order_fifo #(
    .DEPTH (DEPTH),
    .W     (MIDX_W)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .pop   (match),
    .din   (req_mst),
    .head  (head),
    .count (count)
  );

  // Occupancy is the registered count: a pop in this cycle does not free a
  // slot for a push in the same cycle, and an empty FIFO cannot match an ack
  // for an entry being pushed right now.
  always_comb begin
    empty     = (count == '0);
    idx_ok    = 32'(req_mst) < NMST;
    req_ready = ~areset & (32'(count) < DEPTH);
    push      = req_valid & req_ready & idx_ok;

    head_oh = '0;
    if (!empty) head_oh[head] = 1'b1;

    match     = |(m_ack & head_oh);
    sel_rdata = m_rdata[32'(head) * DWIDTH +: DWIDTH];
    sel_resp  = m_resp[head];

    // Any ack outside the head slot is dropped and flagged.
    err_set = (|(m_ack & ~head_oh)) | (req_valid & ~idx_ok);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_ack          <= 1'b0;
      s_resp         <= 1'b0;
      s_rdata        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      s_ack <= match;
      if (match) begin
        s_rdata <= sel_rdata;
        s_resp  <= sel_resp;
      end
      err_unexpected <= err_set | (err_unexpected & ~err_clr);
    end
  end

  always_comb outstanding = count;

endmodule

// File: tb/tb_rd_resp_collector.sv
module tb_rd_resp_collector;

  localparam int DW = 32;
  localparam int NM = 4;
  localparam int DP = 8;

  logic           clk = 1'b0;
  logic           areset;
  logic           req_valid;
  logic [1:0]     req_mst;
  logic           req_ready;
  logic [NM*DW-1:0] m_rdata;
  logic [NM-1:0]  m_resp;
  logic [NM-1:0]  m_ack;
  logic [DW-1:0]  s_rdata;
  logic           s_resp;
  logic           s_ack;
  logic [3:0]     outstanding;
  logic           err_unexpected;
  logic           err_clr;

  // Second instance with three masters so that req_mst can hold an out-of-range index.
  logic           req_valid2;
  logic [1:0]     req_mst2;
  logic           req_ready2;
  logic [3*DW-1:0] m_rdata2;
  logic [2:0]     m_resp2;
  logic [2:0]     m_ack2;
  logic [DW-1:0]  s_rdata2;
  logic           s_resp2;
  logic           s_ack2;
  logic [3:0]     outstanding2;
  logic           err2;

  always #5 clk = ~clk;

  rd_resp_collector #(.DWIDTH(DW), .NMST(NM), .DEPTH(DP)) dut (
    .aclk(clk), .areset(areset), .req_valid(req_valid), .req_mst(req_mst),
    .req_ready(req_ready), .m_rdata(m_rdata), .m_resp(m_resp), .m_ack(m_ack),
    .s_rdata(s_rdata), .s_resp(s_resp), .s_ack(s_ack), .outstanding(outstanding),
    .err_unexpected(err_unexpected), .err_clr(err_clr)
  );

  rd_resp_collector #(.DWIDTH(DW), .NMST(3), .DEPTH(DP)) dut2 (
    .aclk(clk), .areset(areset), .req_valid(req_valid2), .req_mst(req_mst2),
    .req_ready(req_ready2), .m_rdata(m_rdata2), .m_resp(m_resp2), .m_ack(m_ack2),
    .s_rdata(s_rdata2), .s_resp(s_resp2), .s_ack(s_ack2), .outstanding(outstanding2),
    .err_unexpected(err2), .err_clr(1'b0)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rv;
    logic [1:0]  mst;
    logic [3:0]  ack;
    logic [31:0] data;
    logic        resp;
    logic        clr;
    logic        e_ack;
    logic [31:0] e_data;
    logic        e_resp;
    logic [3:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Acked masters carry 'data'; all other slices carry distinct filler so a wrong
  // head-select shows up as wrong data or resp.
  task automatic drive(input logic rv, input logic [1:0] mst, input logic [3:0] ack,
                       input logic [31:0] data, input logic resp, input logic clr);
    req_valid = rv;
    req_mst   = mst;
    m_ack     = ack;
    err_clr   = clr;
    for (int i = 0; i < NM; i++) begin
      if (ack[i]) begin
        m_rdata[i*DW +: DW] = data;
        m_resp[i]           = resp;
      end else begin
        m_rdata[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
        m_resp[i]           = ~resp;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic e_ack, input logic [31:0] e_data,
                           input logic e_resp, input logic [3:0] e_out, input logic e_err);
    chk({name, ".s_ack"}, 32'(s_ack), 32'(e_ack));
    chk({name, ".s_rdata"}, s_rdata, e_data);
    chk({name, ".s_resp"}, 32'(s_resp), 32'(e_resp));
    chk({name, ".outstanding"}, 32'(outstanding), 32'(e_out));
    chk({name, ".err"}, 32'(err_unexpected), 32'(e_err));
  endtask

  initial begin
    //          rv  mst   ack      data          resp clr  e_ack e_data        e_resp e_out e_err
    // in-order: push 2, 0; ack 2 then 0
    vecs[0]  = '{1'b1, 2'd2, 4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'd1, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'd2, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 4'b0100, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 4'd1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 4'b0001, 32'h0000_00FF, 1'b1, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_00FF, 1'b1, 4'd0, 1'b0};
    // out-of-order: push 1, 3; ack 3 first is dropped
    vecs[5]  = '{1'b1, 2'd1, 4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_00FF, 1'b1, 4'd1, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_00FF, 1'b1, 4'd2, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 4'b1000, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0000_00FF, 1'b1, 4'd2, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, 4'b0010, 32'h0000_1111, 1'b0, 1'b0, 1'b1, 32'h0000_1111, 1'b0, 4'd1, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1111, 1'b0, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 4'b1000, 32'h0000_3333, 1'b1, 1'b0, 1'b1, 32'h0000_3333, 1'b1, 4'd0, 1'b0};
    // clear and new error together: the error wins
    vecs[11] = '{1'b0, 2'd0, 4'b0001, 32'h0000_0044, 1'b0, 1'b1, 1'b0, 32'h0000_3333, 1'b1, 4'd0, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_3333, 1'b1, 4'd0, 1'b0};

    areset     = 1'b1;
    req_valid2 = 1'b0;
    req_mst2   = '0;
    m_rdata2   = '0;
    m_resp2    = '0;
    m_ack2     = '0;
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst.req_ready_in_reset", 32'(req_ready), 32'd0);
    areset = 1'b0;
    #1;
    chk("rst.req_ready_after", 32'(req_ready), 32'd1);
    check_out("rst", 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);

    // table vectors
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].rv, vecs[v].mst, vecs[v].ack, vecs[v].data, vecs[v].resp, vecs[v].clr);
      step();
      check_out($sformatf("vec%0d", v), vecs[v].e_ack, vecs[v].e_data, vecs[v].e_resp,
                vecs[v].e_out, vecs[v].e_err);
    end

    // full: 8 pushes of masters 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 4'b0000, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    chk("full.outstanding", 32'(outstanding), 32'd8);
    chk("full.req_ready", 32'(req_ready), 32'd0);
    // push at full alongside a head ack: push refused, count drops to 7
    drive(1'b1, 2'd1, 4'b0001, 32'h4000_0000, 1'b0, 1'b0);
    step();
    check_out("full.pushpop", 1'b1, 32'h4000_0000, 1'b0, 4'd7, 1'b0);
    for (int i = 1; i < 8; i++) begin
      logic [3:0] a;
      a = 4'b0001 << (i % 4);
      drive(1'b0, 2'd0, a, 32'h4000_0000 + 32'(i), i[0], 1'b0);
      step();
      check_out($sformatf("wrap%0d", i), 1'b1, 32'h4000_0000 + 32'(i), i[0], 4'(7 - i), 1'b0);
    end
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    check_out("wrap.idle", 1'b0, 32'h4000_0007, 1'b1, 4'd0, 1'b0);

    // simultaneous push and pop
    drive(1'b1, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd1, 4'b0001, 32'h5555_0000, 1'b1, 1'b0);
    step();
    check_out("sim.pushpop", 1'b1, 32'h5555_0000, 1'b1, 4'd1, 1'b0);
    drive(1'b0, 2'd0, 4'b0010, 32'h5555_0001, 1'b0, 1'b0);
    step();
    check_out("sim.head1", 1'b1, 32'h5555_0001, 1'b0, 4'd0, 1'b0);

    // push into empty with same-master ack: no bypass
    drive(1'b1, 2'd2, 4'b0100, 32'h6666_0000, 1'b1, 1'b0);
    step();
    check_out("nobypass", 1'b0, 32'h5555_0001, 1'b0, 4'd1, 1'b1);
    drive(1'b0, 2'd0, 4'b0100, 32'h6666_0001, 1'b1, 1'b1);
    step();
    check_out("nobypass.ret", 1'b1, 32'h6666_0001, 1'b1, 4'd0, 1'b0);

    // ack with empty FIFO
    drive(1'b0, 2'd0, 4'b0100, 32'h7777_0000, 1'b0, 1'b0);
    step();
    check_out("empty.ack", 1'b0, 32'h6666_0001, 1'b1, 4'd0, 1'b1);
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b1);
    step();
    chk("empty.clr", 32'(err_unexpected), 32'd0);
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);

    // out-of-range index on the three-master instance
    req_valid2 = 1'b1;
    req_mst2   = 2'd3;
    step();
    chk("badidx.outstanding", 32'(outstanding2), 32'd0);
    chk("badidx.err", 32'(err2), 32'd1);
    req_mst2 = 2'd2;
    step();
    req_valid2 = 1'b0;
    chk("goodidx.outstanding", 32'(outstanding2), 32'd1);
    m_ack2 = 3'b100;
    m_rdata2[2*DW +: DW] = 32'h8888_0002;
    step();
    m_ack2 = '0;
    chk("goodidx.s_ack", 32'(s_ack2), 32'd1);
    chk("goodidx.s_rdata", s_rdata2, 32'h8888_0002);

    // reset mid-stream discards outstanding entries
    drive(1'b1, 2'd2, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd3, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    chk("mid.pre_out", 32'(outstanding), 32'd2);
    #2;
    areset = 1'b1;
    #1;
    chk("mid.out_in_reset", 32'(outstanding), 32'd0);
    chk("mid.ready_in_reset", 32'(req_ready), 32'd0);
    step();
    areset = 1'b0;
    #1;
    chk("mid.ready_after", 32'(req_ready), 32'd1);
    check_out("mid.after", 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 2'd0, 4'b0100, 32'h9999_0000, 1'b0, 1'b0);
    step();
    check_out("mid.stale_ack", 1'b0, 32'h0, 1'b0, 4'd0, 1'b1);
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
